dsp_mac_pipelined: RTL and testbench



---
 rtl/dsp_mac_pkg.sv | 28 ++
 rtl/dsp_mac_pipelined_if.sv | 22 ++
 rtl/dsp_mac_mult_stage.sv | 60 ++++++
 rtl/dsp_mac_pipelined.sv | 96 +++++++++
 tb/tb_dsp_mac_pipelined.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: shared types and helpers for the pipelined MAC.
//   PIPE_LATENCY : register stages from input launch to p / out_valid
//   side_t       : per-sample sideband that travels alongside the data
//   ext_to_acc   : sign- or zero-extend the low 'width' bits of a value
package dsp_mac_pkg;

  localparam int PIPE_LATENCY = 3;
  localparam int EXT_W        = 128;

  typedef struct packed {
    logic signed_mode;
    logic load;
    logic valid;
  } side_t;

  // Bits at and above 'width' are replaced by the sign bit (signed_mode=1)
  // or by zeros. The caller truncates the result to its own width.
  function automatic logic [EXT_W-1:0] ext_to_acc(input logic [EXT_W-1:0] value,
                                                  input int width,
                                                  input logic signed_mode);
    logic [EXT_W-1:0] keep;
    logic             sgn;
    keep = (EXT_W'(1) << width) - EXT_W'(1);
    sgn  = |(value & (EXT_W'(1) << (width - 1)));
    return (value & keep) | ({EXT_W{signed_mode & sgn}} & ~keep);
  endfunction

endpackage

// File: rtl/dsp_mac_pipelined_if.sv
// dsp_mac_pipelined_if: sample stream into the MAC and result stream out.
//   in_valid/a/b/signed_mode/load : sample from the source (master drives)
//   out_valid/p/overflow          : accumulator result (slave drives)
interface dsp_mac_pipelined_if #(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48
);
  logic                 in_valid;
  logic [A_WIDTH-1:0]   a;
  logic [B_WIDTH-1:0]   b;
  logic                 signed_mode;
  logic                 load;
  logic                 out_valid;
  logic [ACC_WIDTH-1:0] p;
  logic                 overflow;

  modport master (output in_valid, a, b, signed_mode, load,
                  input  out_valid, p, overflow);
  modport slave  (input  in_valid, a, b, signed_mode, load,
                  output out_valid, p, overflow);
endinterface

// File: rtl/dsp_mac_mult_stage.sv
// dsp_mac_mult_stage: S1 operand/sideband registers and S2 registered
// extended multiply.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid, a, b,
//   signed_mode, load     : incoming sample
//   prod                  : S2 product, A_WIDTH+B_WIDTH bits
//   side                  : S2 sideband aligned with prod
module dsp_mac_mult_stage
  import dsp_mac_pkg::*;
#(
  parameter  int A_WIDTH = 20,
  parameter  int B_WIDTH = 18,
  localparam int PW      = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               signed_mode,
  input  logic               load,
  output logic [PW-1:0]      prod,
  output side_t              side
);
  logic [A_WIDTH-1:0] a_d, a_q;
  logic [B_WIDTH-1:0] b_d, b_q;
  side_t              s1_d, s1_q, s2_d, s2_q;
  logic [PW-1:0]      a_ext, b_ext, prod_d, prod_q;

  // Both operands are extended to the full product width, so the low PW
  // bits of the product are correct for signed and unsigned alike.
  always_comb begin
    a_d    = a;
    b_d    = b;
    s1_d   = '{signed_mode: signed_mode, load: load, valid: in_valid};
    a_ext  = PW'(ext_to_acc(EXT_W'(a_q), A_WIDTH, s1_q.signed_mode));
    b_ext  = PW'(ext_to_acc(EXT_W'(b_q), B_WIDTH, s1_q.signed_mode));
    prod_d = a_ext * b_ext;
    s2_d   = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prod_q <= prod_d;
    end
  end

  assign prod = prod_q;
  assign side = s2_q;
endmodule

// File: rtl/dsp_mac_pipelined.sv
// dsp_mac_pipelined: 3-stage pipelined signed/unsigned multiply-accumulate.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dsp_mac_pipelined_if.slave (sample in, accumulator out)
// Build option DSP_MAC_SAT_EN: saturating accumulate with sticky overflow;
// without it the accumulator wraps and overflow stays 0.
module dsp_mac_pipelined
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  dsp_mac_pipelined_if.slave    bus
);
  localparam int PW = A_WIDTH + B_WIDTH;

  generate
    if (ACC_WIDTH < PW) begin : g_width_chk
      $error("ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
  endgenerate

  logic [PW-1:0]        prod;
  side_t                side;
  logic [ACC_WIDTH-1:0] prod_ext, sum, acc_d, acc_q;
  logic                 out_valid_d, out_valid_q;

  dsp_mac_mult_stage #(.A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH)) u_mult (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (bus.in_valid),
    .a           (bus.a),
    .b           (bus.b),
    .signed_mode (bus.signed_mode),
    .load        (bus.load),
    .prod        (prod),
    .side        (side)
  );

`ifdef DSP_MAC_SAT_EN
  logic ovf_d, ovf_q, sum_ovf;
`endif

  always_comb begin
    prod_ext    = ACC_WIDTH'(ext_to_acc(EXT_W'(prod), PW, side.signed_mode));
    sum         = acc_q + prod_ext;
    acc_d       = acc_q;
    out_valid_d = side.valid;
`ifdef DSP_MAC_SAT_EN
    ovf_d   = ovf_q;
    // Same-sign operands whose sum flips sign have left the signed range.
    sum_ovf = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
              (sum[ACC_WIDTH-1]   != acc_q[ACC_WIDTH-1]);
    if (side.valid) begin
      if (side.load) begin
        acc_d = prod_ext;
        ovf_d = 1'b0;
      end else if (sum_ovf) begin
        acc_d = acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        ovf_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
`else
    if (side.valid) acc_d = side.load ? prod_ext : sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef DSP_MAC_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
`ifdef DSP_MAC_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.p         = acc_q;
  assign bus.out_valid = out_valid_q;
`ifdef DSP_MAC_SAT_EN
  assign bus.overflow  = ovf_q;
`else
  assign bus.overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_dsp_mac_pipelined.sv
module tb_dsp_mac_pipelined;
  import dsp_mac_pkg::*;

  typedef struct {
    longint p;
    bit     ovf;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_mac_pipelined_if #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(48)) if48 ();
  dsp_mac_pipelined_if #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(38)) if38 ();

  dsp_mac_pipelined #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(48)) u48 (
    .clk(clk), .reset(reset), .bus(if48));
  dsp_mac_pipelined #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(38)) u38 (
    .clk(clk), .reset(reset), .bus(if38));

  // Reference model: integer arithmetic on true values
  exp_t   q48[$], q38[$];
  exp_t   e48, e38;
  longint acc48 = 0, acc38 = 0, last48 = 0, last38 = 0;
  bit     ovf48 = 0, ovf38 = 0, lov48 = 0, lov38 = 0;

  function automatic longint wrapw(input longint v, input int w);
    longint m, r;
    m = longint'(1) <<< w;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  function automatic void step(input int w, input longint prod, input bit ld,
                               inout longint acc, inout bit ovf);
    longint pv, s, mx, mn;
    pv = wrapw(prod, w);
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    if (ld) begin
      acc = pv;
      ovf = 1'b0;
    end else begin
      s = acc + pv;
`ifdef DSP_MAC_SAT_EN
      if (s > mx) begin acc = mx; ovf = 1'b1; end
      else if (s < mn) begin acc = mn; ovf = 1'b1; end
      else acc = s;
`else
      acc = wrapw(s, w);
      ovf = 1'b0;
`endif
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  task automatic set_inputs(input bit v, input logic [19:0] av, input logic [17:0] bv,
                            input bit sm, input bit ld);
    if48.in_valid = v; if48.a = av; if48.b = bv; if48.signed_mode = sm; if48.load = ld;
    if38.in_valid = v; if38.a = av; if38.b = bv; if38.signed_mode = sm; if38.load = ld;
  endtask

  task automatic drive(input bit v, input logic [19:0] av, input logic [17:0] bv,
                       input bit sm, input bit ld);
    longint pa, pb;
    @(posedge clk); #1;
    set_inputs(v, av, bv, sm, ld);
    if (v) begin
      pa = sm ? longint'($signed(av)) : longint'(av);
      pb = sm ? longint'($signed(bv)) : longint'(bv);
      step(48, pa * pb, ld, acc48, ovf48);
      step(38, pa * pb, ld, acc38, ovf38);
      q48.push_back('{acc48, ovf48, cyc + PIPE_LATENCY});
      q38.push_back('{acc38, ovf38, cyc + PIPE_LATENCY});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if48.in_valid = 1'b0; if38.in_valid = 1'b0;
    end
  endtask

  // Asserts reset immediately (between edges) with in_valid held high.
  task automatic do_reset(input int n);
    reset = 1'b1;
    if48.in_valid = 1'b1; if38.in_valid = 1'b1;
    q48.delete(); q38.delete();
    acc48 = 0; acc38 = 0; ovf48 = 0; ovf38 = 0;
    last48 = 0; last38 = 0; lov48 = 0; lov38 = 0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    if48.in_valid = 1'b0; if38.in_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (if48.out_valid) begin
        if (q48.size() == 0) chk("spurious48", 64'(if48.out_valid), 64'(0));
        else begin
          e48 = q48.pop_front();
          chk("p48",   64'(if48.p),        64'(e48.p[47:0]));
          chk("ovf48", 64'(if48.overflow), 64'(e48.ovf));
          chk("lat48", 64'(cyc),           64'(e48.cyc));
          last48 = e48.p; lov48 = e48.ovf;
        end
      end else begin
        chk("hold48",  64'(if48.p),        64'(last48[47:0]));
        chk("hovf48",  64'(if48.overflow), 64'(lov48));
      end
      if (if38.out_valid) begin
        if (q38.size() == 0) chk("spurious38", 64'(if38.out_valid), 64'(0));
        else begin
          e38 = q38.pop_front();
          chk("p38",   64'(if38.p),        64'(e38.p[37:0]));
          chk("ovf38", 64'(if38.overflow), 64'(e38.ovf));
          chk("lat38", 64'(cyc),           64'(e38.cyc));
          last38 = e38.p; lov38 = e38.ovf;
        end
      end else begin
        chk("hold38",  64'(if38.p),        64'(last38[37:0]));
        chk("hovf38",  64'(if38.overflow), 64'(lov38));
      end
    end
  end

  logic [37:0] sat_exp;
  bit          sat_ov;

  initial begin
    set_inputs(1'b0, '0, '0, 1'b0, 1'b0);
    do_reset(2);
    idle(2);
    chk("rst_p48",  64'(if48.p),         64'(0));
    chk("rst_ov48", 64'(if48.out_valid), 64'(0));
    chk("rst_of48", 64'(if48.overflow),  64'(0));
    chk("rst_p38",  64'(if38.p),         64'(0));

    drive(1, 20'd5, 18'd2, 1, 1); idle(PIPE_LATENCY);
    chk("dir_5x2", 64'(if48.p), 64'(48'd10));
    drive(1, 20'hFFFFD, 18'd7, 1, 1); idle(PIPE_LATENCY);
    chk("dir_m3x7", 64'(if48.p), 64'(48'hFFFF_FFFF_FFEB));
    drive(1, 20'hFFFFF, 18'd2, 0, 1); idle(PIPE_LATENCY);
    chk("dir_unsigned", 64'(if48.p), 64'(48'd2097150));

    drive(1, 20'd3, 18'd4, 1, 1);
    drive(1, 20'd5, 18'd6, 1, 0);
    drive(1, 20'hFFFFE, 18'd10, 1, 0);
    idle(PIPE_LATENCY);
    chk("stream_final", 64'(if48.p), 64'(48'd22));

    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) drive(0, 20'($urandom), 18'($urandom), 1'($urandom), 1'($urandom));
      drive(1, 20'($urandom), 18'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
    end
    idle(PIPE_LATENCY + 2);

    drive(1, 20'd7, 18'd9, 0, 1);
    drive(1, 20'd11, 18'd13, 1, 0);
    drive(1, 20'd17, 18'd19, 0, 0);
    do_reset(1);
    idle(6);
    chk("midrst_p48", 64'(if48.p), 64'(0));
    chk("midrst_p38", 64'(if38.p), 64'(0));

    drive(1, 20'h80000, 18'h20000, 1, 1);
    drive(1, 20'h80000, 18'h20000, 1, 0);
    idle(PIPE_LATENCY);
`ifdef DSP_MAC_SAT_EN
    sat_exp = 38'h1F_FFFF_FFFF; sat_ov = 1'b1;
`else
    sat_exp = 38'h20_0000_0000; sat_ov = 1'b0;
`endif
    chk("sat_p38",  64'(if38.p),        64'(sat_exp));
    chk("sat_ov38", 64'(if38.overflow), 64'(sat_ov));
    chk("nosat_p48", 64'(if48.p), 64'(48'h20_0000_0000));

    for (int i = 0; i < 20 && (q48.size() + q38.size()) != 0; i++) idle(1);
    chk("drain", 64'(q48.size() + q38.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
